sr_muldiv_seq: RTL and testbench



---
 rtl/sr_muldiv_seq_pkg.sv | 26 ++
 rtl/sr_muldiv_step.sv | 35 +++
 rtl/sr_muldiv_seq.sv | 114 +++++++++++
 tb/tb_sr_muldiv_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sr_muldiv_seq_pkg.sv
// Shared constants for the schoolRISCV iterative multiply/divide sequencer:
// operation and FSM state encodings plus the M-extension decode fields.
package sr_muldiv_seq_pkg;

    localparam logic [1:0] MD_OP_MUL   = 2'd0;
    localparam logic [1:0] MD_OP_MULHU = 2'd1;
    localparam logic [1:0] MD_OP_DIVU  = 2'd2;
    localparam logic [1:0] MD_OP_REMU  = 2'd3;

    localparam logic [1:0] MD_ST_IDLE  = 2'd0;
    localparam logic [1:0] MD_ST_CALC  = 2'd1;
    localparam logic [1:0] MD_ST_DONE  = 2'd2;

    // funct7/funct3 values that sr_control uses to recognise M-ops
    localparam logic [6:0] RVF7_MULDIV = 7'b0000001;
    localparam logic [2:0] RVF3_MUL    = 3'b000;
    localparam logic [2:0] RVF3_MULHU  = 3'b011;
    localparam logic [2:0] RVF3_DIVU   = 3'b101;
    localparam logic [2:0] RVF3_REMU   = 3'b111;

    // MULHU and REMU take their answer from the upper working register
    function automatic logic mdResultIsHigh(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/sr_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply or restoring
// shift-subtract for divide, chosen by isDiv_i.
module sr_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             isDiv_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH-1:0] divDiff;
    logic             divKeep;

    // The remainder always stays below the divisor, so after the left shift
    // it fits in WIDTH+1 bits and a kept difference fits back in WIDTH bits.
    always_comb begin
        mulSum   = {1'b0, hi_i} + {1'b0, (lo_i[0] ? operand_i : '0)};
        divShift = {hi_i, lo_i[WIDTH-1]};
        divKeep  = (divShift >= {1'b0, operand_i});
        divDiff  = divShift[WIDTH-1:0] - operand_i;
        if (isDiv_i) begin
            hi_o = divKeep ? divDiff : divShift[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], divKeep};
        end else begin
            hi_o = mulSum[WIDTH:1];
            lo_o = {mulSum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sr_muldiv_seq.sv
// Iterative MUL/MULHU/DIVU/REMU sequencer that stalls the core while busy.
// Optional zero-operand shortcut enabled by SR_MULDIV_ZERO_BYPASS_EN.
module sr_muldiv_seq
    import sr_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] stepHi, stepLo;

    // Multiply keeps the multiplier in lo and adds srcA; divide keeps the
    // dividend in lo (quotient) and subtracts srcB.
    sr_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .isDiv_i   (op_q[1]),
        .hi_i      (hi_q),
        .lo_i      (lo_q),
        .operand_i (operand_q),
        .hi_o      (stepHi),
        .lo_o      (stepLo)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        operand_d = operand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        stall     = 1'b0;
        case (state_q)
            MD_ST_IDLE: begin
                stall = start;
                if (start) begin
                    op_d      = op;
                    operand_d = op[1] ? srcB : srcA;
                    lo_d      = op[1] ? srcA : srcB;
                    hi_d      = '0;
                    count_d   = CW'(WIDTH - 1);
                    state_d   = MD_ST_CALC;
`ifdef SR_MULDIV_ZERO_BYPASS_EN
                    if ((srcA == '0) || (srcB == '0)) begin
                        state_d = MD_ST_DONE;
                        case (op)
                            MD_OP_DIVU: result_d = (srcB == '0) ? '1 : '0;
                            MD_OP_REMU: result_d = srcA;
                            default:    result_d = '0;
                        endcase
                    end
`else
                    state_d = MD_ST_CALC;
`endif
                end
            end
            MD_ST_CALC: begin
                stall = 1'b1;
                hi_d  = stepHi;
                lo_d  = stepLo;
                if (count_q == '0) begin
                    state_d  = MD_ST_DONE;
                    result_d = mdResultIsHigh(op_q) ? stepHi : stepLo;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            // start here still belongs to the retiring instruction
            MD_ST_DONE: state_d = MD_ST_IDLE;
            default:    state_d = MD_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MD_ST_IDLE;
            count_q   <= '0;
            op_q      <= MD_OP_MUL;
            operand_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
        end
    end

    assign done   = (state_q == MD_ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_sr_muldiv_seq.sv
// Directed self-checking bench for sr_muldiv_seq with hand-computed vectors.
module tb_sr_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int vectors     = 0;
    int miscompares = 0;
    int cycleNum    = 0;
    int donePulses  = 0;

`ifdef SR_MULDIV_ZERO_BYPASS_EN
    localparam int ZC = 1;
`else
    localparam int ZC = 33;
`endif

    sr_muldiv_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .srcA   (srcA),
        .srcB   (srcB),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Free-running cycle index and done-pulse tally, sampled mid-cycle
    always @(negedge clk) begin
        cycleNum++;
        if (done === 1'b1) donePulses++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic s);
        op    = o;
        srcA  = a;
        srcB  = b;
        start = s;
    endtask

    // Issue one op at a negedge (cycle 0) and follow it to its done cycle
    task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input int expCycles, input string tag,
                         input bit keepStart, output int doneAt);
        int cyc;
        int stallCnt;
        bit seen;
        cyc      = 0;
        stallCnt = 0;
        seen     = 1'b0;
        @(negedge clk);
        applyStimulus(o, a, b, 1'b1);
        while (!seen && cyc < 200) begin
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (stall === 1'b1) stallCnt++;
                @(negedge clk);
                cyc++;
                if (cyc == 5) begin
                    srcA = ~a;
                    srcB = ~b;
                end
            end
        end
        doneAt = cycleNum;
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_done_cycle"}, 32'(cyc), 32'(expCycles));
        checkOutput({tag, "_stall_cycles"}, 32'(stallCnt), 32'(expCycles));
        checkOutput({tag, "_stall_in_done"}, 32'(stall), 32'd0);
        checkOutput({tag, "_result"}, result, expRes);
        if (!keepStart) begin
            start = 1'b0;
            @(negedge clk);
            #1;
            checkOutput({tag, "_done_pulse_width"}, 32'(done), 32'd0);
            checkOutput({tag, "_idle_stall"}, 32'(stall), 32'd0);
            checkOutput({tag, "_result_held"}, result, expRes);
        end
    endtask

    initial begin
        int t0, t1, p0;
        rst = 1'b1;
        applyStimulus(2'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst = 1'b0;

        runOp(2'd0, 32'd7, 32'd6, 32'd42, 33, "mul_7x6", 1'b0, t0);
        runOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max", 1'b0, t0);
        runOp(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul_max", 1'b0, t0);
        runOp(2'd1, 32'h8000_0000, 32'd4, 32'd2, 33, "mulhu_msb", 1'b0, t0);
        runOp(2'd2, 32'd100, 32'd7, 32'd14, 33, "divu_100_7", 1'b0, t0);
        runOp(2'd3, 32'd100, 32'd7, 32'd2, 33, "remu_100_7", 1'b0, t0);
        runOp(2'd2, 32'd7, 32'd100, 32'd0, 33, "divu_7_100", 1'b0, t0);
        runOp(2'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, ZC, "divu_div0", 1'b0, t0);
        runOp(2'd0, 32'd0, 32'd5, 32'd0, ZC, "mul_zero", 1'b0, t0);
        runOp(2'd3, 32'd5, 32'd0, 32'd5, ZC, "remu_div0", 1'b0, t0);

        // Abort a divide in cycle 10 with reset
        @(negedge clk);
        applyStimulus(2'd2, 32'd1000, 32'd3, 1'b1);
        repeat (10) @(negedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        checkOutput("abort_stall", 32'(stall), 32'd0);
        checkOutput("abort_result", result, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("abort_next_done", 32'(done), 32'd0);
        checkOutput("abort_next_result", result, 32'd0);
        rst = 1'b0;
        p0  = donePulses;
        repeat (40) @(negedge clk);
        #1;
        checkOutput("abort_no_done", 32'(donePulses - p0), 32'd0);
        runOp(2'd0, 32'd3, 32'd3, 32'd9, 33, "mul_after_abort", 1'b0, t0);

        // Back-to-back with start held high across both instructions
        p0 = donePulses;
        runOp(2'd0, 32'd2, 32'd3, 32'd6, 33, "b2b_mul", 1'b1, t0);
        runOp(2'd2, 32'd9, 32'd2, 32'd4, 33, "b2b_divu", 1'b1, t1);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("b2b_done_count", 32'(donePulses - p0), 32'd2);
        checkOutput("b2b_done_gap", 32'(t1 - t0), 32'd34);
        checkOutput("b2b_result_held", result, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
